// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle between the ALU sequencer and the serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = serial_subtractor_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_borrow;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out_diff;
  logic             out_borrow;
  logic             out_ovf;

  modport master (
    output start, in_a, in_b, in_borrow,
    input  busy, done, out_diff, out_borrow, out_ovf
  );

  modport slave (
    input  start, in_a, in_b, in_borrow,
    output busy, done, out_diff, out_borrow, out_ovf
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational one-bit full-subtractor cell: d = a - b - bin, with borrow out.
module serial_subtractor_full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one subtractor cell and a borrow flop reused for WIDTH cycles.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_sh;
  logic             bor_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic             d_bit;
  logic             bout_bit;
  logic             busy_c;
  logic             done_c;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] out_diff_q;
  logic             out_borrow_q;
  logic             out_ovf_q;

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (a_msb ^ d_msb);
  endfunction

  serial_subtractor_full_subtractor u_full_subtractor (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bor_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign accept   = (state_q == ST_IDLE) && bus.start;
  assign last_bit = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy_c = 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_c  = 1'b1;
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control: state, bit counter and the architecturally visible result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      out_diff_q   <= '0;
      out_borrow_q <= 1'b0;
      out_ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= '0;
      end else if ((state_q == ST_RUN) && (cnt_q != CNT_LAST)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // The last bit is folded straight into the result so it is valid in DONE.
      if (last_bit) begin
        out_diff_q   <= {d_bit, diff_sh[WIDTH-1:1]};
        out_borrow_q <= bout_bit;
        out_ovf_q    <= signed_ovf(a_msb_q, b_msb_q, d_bit);
      end
    end
  end

  // Datapath: operand shift registers, borrow flop and partial difference; no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh    <= bus.in_a;
      b_sh    <= bus.in_b;
      bor_q   <= bus.in_borrow;
      a_msb_q <= bus.in_a[WIDTH-1];
      b_msb_q <= bus.in_b[WIDTH-1];
    end else if (state_q == ST_RUN) begin
      a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
      bor_q   <= bout_bit;
      diff_sh <= {d_bit, diff_sh[WIDTH-1:1]};
    end
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.out_diff   = out_diff_q;
  assign bus.out_borrow = out_borrow_q;
  assign bus.out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, handshake corner cases, random ops.
module tb_serial_subtractor;

  localparam int W     = 32;
  localparam int LIMIT = 4 * W;
  localparam int NVEC  = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h required %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference: unsigned W+1-bit difference gives the borrow, wide signed difference gives overflow.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] u;
    longint     s;
    longint     smax;
    longint     smin;
    logic       ovf;
    u    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    s    = longint'($signed(a)) - longint'($signed(b)) - longint'({63'd0, bin});
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    ovf  = (s > smax) || (s < smin);
    return {ovf, u};
  endfunction

  task automatic wait_done(inout int cyc);
    while (!bus.done && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output logic [W+1:0] res, output int lat);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_borrow = bin;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.in_a      = $urandom;
    bus.in_b      = $urandom;
    bus.in_borrow = 1'($urandom);
    chk("busy_run", 64'(bus.busy), 64'd1);
    lat = 0;
    wait_done(lat);
    res = {bus.out_ovf, bus.out_borrow, bus.out_diff};
  endtask

  vec_t         vecs[NVEC];
  logic [W+1:0] res;
  logic [W+1:0] res2;
  logic [W+1:0] exp_r;
  int           lat;
  int           cyc;
  int           pulses;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic         rbin;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    vecs[0] = '{32'd5,          32'd3,          1'b0, 32'd2,          1'b0, 1'b0};
    vecs[1] = '{32'd3,          32'd5,          1'b0, 32'hFFFFFFFE,   1'b1, 1'b0};
    vecs[2] = '{32'h80000000,   32'd1,          1'b0, 32'h7FFFFFFF,   1'b0, 1'b1};
    vecs[3] = '{32'h7FFFFFFF,   32'hFFFFFFFF,   1'b0, 32'h80000000,   1'b1, 1'b1};
    vecs[4] = '{32'd0,          32'd0,          1'b1, 32'hFFFFFFFF,   1'b1, 1'b0};
    vecs[5] = '{32'hA5A5A5A5,   32'hA5A5A5A5,   1'b0, 32'd0,          1'b0, 1'b0};
    vecs[6] = '{32'd0,          32'h80000000,   1'b0, 32'h80000000,   1'b1, 1'b1};
    vecs[7] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 32'hFFFFFFFF,   1'b1, 1'b0};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_borrow = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_outs", 64'({bus.out_ovf, bus.out_borrow, bus.out_diff}), 64'd0);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < NVEC; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, res, lat);
      chk($sformatf("vec%0d_diff", i),   64'(res[W-1:0]), 64'(vecs[i].diff));
      chk($sformatf("vec%0d_borrow", i), 64'(res[W]),     64'(vecs[i].borrow));
      chk($sformatf("vec%0d_ovf", i),    64'(res[W+1]),   64'(vecs[i].ovf));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(W));
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), 64'(bus.done), 64'd0);
      chk($sformatf("vec%0d_hold", i), 64'({bus.out_ovf, bus.out_borrow, bus.out_diff}), 64'(res));
    end

    // Start during RUN is ignored and not queued.
    @(negedge clk);
    bus.start = 1'b1; bus.in_a = 32'd1000; bus.in_b = 32'd1; bus.in_borrow = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    repeat (10) begin @(negedge clk); cyc++; end
    bus.start = 1'b1; bus.in_a = 32'd7; bus.in_b = 32'd9; bus.in_borrow = 1'b1;
    @(negedge clk);
    cyc++;
    bus.start = 1'b0;
    wait_done(cyc);
    chk("ign_latency", 64'(cyc), 64'(W));
    chk("ign_result", 64'({bus.out_ovf, bus.out_borrow, bus.out_diff}), 64'(ref_sub(32'd1000, 32'd1, 1'b0)));
    pulses = 0;
    repeat (W + 4) begin @(negedge clk); if (bus.done) pulses++; end
    chk("ign_extra_done", 64'(pulses), 64'd0);
    chk("ign_idle", 64'(bus.busy), 64'd0);

    // Start held high: second op accepted on the first IDLE cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.in_a = 32'h12345678; bus.in_b = 32'h00000678; bus.in_borrow = 1'b0;
    @(negedge clk);
    bus.in_a = 32'h00000010; bus.in_b = 32'h00000020; bus.in_borrow = 1'b1;
    cyc = 0;
    wait_done(cyc);
    chk("b2b_first_latency", 64'(cyc), 64'(W));
    res = {bus.out_ovf, bus.out_borrow, bus.out_diff};
    chk("b2b_first_result", 64'(res), 64'(ref_sub(32'h12345678, 32'h00000678, 1'b0)));
    @(negedge clk);
    cyc++;
    chk("b2b_idle_gap", 64'(bus.busy), 64'd0);
    @(negedge clk);
    cyc++;
    chk("b2b_reaccept", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    wait_done(cyc);
    chk("b2b_spacing", 64'(cyc - W), 64'(W + 2));
    res2 = {bus.out_ovf, bus.out_borrow, bus.out_diff};
    chk("b2b_second_result", 64'(res2), 64'(ref_sub(32'h00000010, 32'h00000020, 1'b1)));

    // Reset mid-RUN abandons the operation.
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.in_a = 32'h00000001; bus.in_b = 32'h00000002; bus.in_borrow = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_outs", 64'({bus.out_ovf, bus.out_borrow, bus.out_diff}), 64'd0);
    pulses = 0;
    repeat (W + 4) begin @(negedge clk); if (bus.done) pulses++; end
    chk("midrst_no_done", 64'(pulses), 64'd0);
    do_op(32'hDEADBEEF, 32'h0BADF00D, 1'b1, res, lat);
    chk("post_rst_result", 64'(res), 64'(ref_sub(32'hDEADBEEF, 32'h0BADF00D, 1'b1)));
    chk("post_rst_latency", 64'(lat), 64'(W));

    // Random operands with 0-3 idle cycles of start jitter.
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ra   = $urandom;
      rb   = $urandom;
      rbin = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      if (i % 8 == 1) ra = {1'b1, {(W-1){1'b0}}};
      do_op(ra, rb, rbin, res, lat);
      exp_r = ref_sub(ra, rb, rbin);
      chk($sformatf("rand%0d a=%0h b=%0h bin=%0d", i, ra, rb, rbin), 64'(res), 64'(exp_r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
